// File: rtl/serial_word_rx_if.sv
// Serial receive bundle: one line in from the flip-flop stage, parallel word plus status out.
// Latency: none (wires only).
// Backpressure: none; the consumer must accept every valid strobe.
interface serial_word_rx_if #(
    parameter int WIDTH = 8
);
    logic             datin;
    logic [WIDTH-1:0] datout;
    logic             valid;
    logic             frame_err;
    logic             parity_err;
    logic             busy;

    // Source side: drives the serial line, observes the receiver results.
    modport master (
        output datin,
        input  datout,
        input  valid,
        input  frame_err,
        input  parity_err,
        input  busy
    );

    // Receiver side.
    modport slave (
        input  datin,
        output datout,
        output valid,
        output frame_err,
        output parity_err,
        output busy
    );
endinterface

// File: rtl/serial_word_rx.sv
// Deserialises framed words (start, WIDTH data bits LSB first, optional even parity, stop).
// Latency: strobes and datout appear one cycle after the stop-bit edge.
// Backpressure: none; one bit is consumed every clk and strobes last exactly one cycle.
module serial_word_rx #(
    parameter int WIDTH     = 8,
    parameter bit PARITY_EN = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    serial_word_rx_if.slave   bus
);

    // Sized so the counter can hold WIDTH itself without wrapping mid-frame.
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("serial_word_rx: WIDTH must be in 2..32");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PAR  = 2'd2,
        STOP = 2'd3
    } state_t;

    state_t           state_q,      state_d;
    logic [CNT_W-1:0] cnt_q,        cnt_d;
    logic [WIDTH-1:0] shift_q,      shift_d;
    logic [WIDTH-1:0] datout_q,     datout_d;
    logic             par_q,        par_d;
    logic             valid_q,      valid_d;
    logic             frame_err_q,  frame_err_d;
    logic             parity_err_q, parity_err_d;
    logic             busy_q,       busy_d;
    logic             parity_ok;

    // Even parity holds when data bits plus the received parity bit XOR to zero.
    assign parity_ok = !PARITY_EN || (((^shift_q) ^ par_q) == 1'b0);

    // Next-state, datapath and strobe computation for the frame FSM.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        shift_d      = shift_q;
        par_d        = par_q;
        datout_d     = datout_q;
        valid_d      = 1'b0;
        frame_err_d  = 1'b0;
        parity_err_d = 1'b0;

        case (state_q)
            IDLE: begin
                // A low line is a start bit; no idle bits needed after a stop.
                if (!bus.datin) begin
                    state_d = DATA;
                    cnt_d   = '0;
                end
            end
            DATA: begin
                // Shift right from the MSB so the first data bit lands in bit 0.
                shift_d = {bus.datin, shift_q[WIDTH-1:1]};
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    state_d = PARITY_EN ? PAR : STOP;
                end
            end
            PAR: begin
                par_d   = bus.datin;
                state_d = STOP;
            end
            STOP: begin
                state_d = IDLE;
                // A bad stop bit masks any parity result.
                if (!bus.datin) begin
                    frame_err_d = 1'b1;
                end else if (parity_ok) begin
                    valid_d  = 1'b1;
                    datout_d = shift_q;
                end else begin
                    parity_err_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Registered busy mirrors the state the FSM is about to enter.
        busy_d = (state_d != IDLE);
    end

    // State and registered outputs; reset aborts any frame in progress silently.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            shift_q      <= '0;
            par_q        <= 1'b0;
            datout_q     <= '0;
            valid_q      <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            par_q        <= par_d;
            datout_q     <= datout_d;
            valid_q      <= valid_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.datout     = datout_q;
    assign bus.valid      = valid_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.parity_err = parity_err_q;
    assign bus.busy       = busy_q;

    // At most one status strobe per frame.
    a_strobes_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0({valid_q, frame_err_q, parity_err_q}));

    // Without a parity bit there is nothing to mismatch.
    a_no_parity_err: assert property (@(posedge clk) disable iff (!rst_n)
        !PARITY_EN |-> !parity_err_q);

    // busy tracks the FSM being anywhere but IDLE.
    a_busy_state: assert property (@(posedge clk) disable iff (!rst_n)
        busy_q == (state_q != IDLE));

endmodule

// File: tb/tb_serial_word_rx.sv
module tb_serial_word_rx;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    serial_word_rx_if #(.WIDTH(8)) if0 ();
    serial_word_rx_if #(.WIDTH(8)) if1 ();

    serial_word_rx #(.WIDTH(8), .PARITY_EN(1'b0)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if0)
    );

    serial_word_rx #(.WIDTH(8), .PARITY_EN(1'b1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1)
    );

    typedef struct {
        logic       rst_n;
        logic       din;
        logic [7:0] dat;
        logic       vld;
        logic       ferr;
        logic       busy;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    function automatic void add(input logic r, input logic d, input logic [7:0] dat,
                                input logic v, input logic f, input logic b);
        vec_t x;
        x.rst_n = r; x.din = d; x.dat = dat; x.vld = v; x.ferr = f; x.busy = b;
        vecs.push_back(x);
    endfunction

    // One frame for the no-parity receiver: start, 8 data bits LSB first, stop.
    function automatic void add_frame(input logic [7:0] d, input logic stop,
                                      input logic [7:0] dat_before, input logic [7:0] dat_after);
        add(1'b1, 1'b0, dat_before, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) add(1'b1, d[i], dat_before, 1'b0, 1'b0, 1'b1);
        add(1'b1, stop, dat_after, stop, !stop, 1'b0);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step1(input logic b);
        if1.datin = b;
        @(posedge clk);
        #1;
    endtask

    // Parity receiver: sends one framed word and checks busy through the frame,
    // then the strobe pattern and datout, then that the strobe drops.
    task automatic send1(input string name, input logic [7:0] d, input logic p, input logic s,
                         input logic ev, input logic ep, input logic ef, input logic [7:0] edat);
        logic [9:0] bits;
        bits = {p, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            step1(bits[i]);
            chk($sformatf("%s busy bit%0d", name, i), if1.busy, 1'b1);
            chk($sformatf("%s quiet bit%0d", name, i),
                {if1.valid, if1.parity_err, if1.frame_err}, 3'b000);
        end
        step1(s);
        chk({name, " valid"},      if1.valid,      ev);
        chk({name, " parity_err"}, if1.parity_err, ep);
        chk({name, " frame_err"},  if1.frame_err,  ef);
        chk({name, " datout"},     if1.datout,     edat);
        chk({name, " busy end"},   if1.busy,       1'b0);
        step1(1'b1);
        chk({name, " strobe drop"}, {if1.valid, if1.parity_err, if1.frame_err}, 3'b000);
    endtask

    initial begin
        rst_n     = 1'b0;
        if0.datin = 1'b1;
        if1.datin = 1'b1;

        // Reset with the line toggling, then release on an idle line.
        add(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        add(1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        add(1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        // Good 0xA5 frame, then an idle bit.
        add_frame(8'hA5, 1'b1, 8'h00, 8'hA5);
        add(1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
        // 0x5A with a low stop bit: frame error, datout held.
        add_frame(8'h5A, 1'b0, 8'hA5, 8'hA5);
        // Line still low right after the error: taken as a new start bit.
        add_frame(8'h00, 1'b1, 8'hA5, 8'h00);
        // Back-to-back 0xA5 then 0x3C with no idle bit between.
        add_frame(8'hA5, 1'b1, 8'h00, 8'hA5);
        add_frame(8'h3C, 1'b1, 8'hA5, 8'h3C);
        add(1'b1, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
        // Reset after four data bits of 0xFF aborts without a strobe.
        add(1'b1, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) add(1'b1, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b1);
        add(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        add(1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        add_frame(8'h81, 1'b1, 8'h00, 8'h81);
        add(1'b1, 1'b1, 8'h81, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            rst_n     = vecs[i].rst_n;
            if0.datin = vecs[i].din;
            if1.datin = 1'b1;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d datout", i),     if0.datout,     vecs[i].dat);
            chk($sformatf("v%0d valid", i),      if0.valid,      vecs[i].vld);
            chk($sformatf("v%0d frame_err", i),  if0.frame_err,  vecs[i].ferr);
            chk($sformatf("v%0d parity_err", i), if0.parity_err, 1'b0);
            chk($sformatf("v%0d busy", i),       if0.busy,       vecs[i].busy);
        end

        // Parity receiver came through the same reset and has seen only idle.
        chk("p reset datout", if1.datout, 8'h00);
        chk("p reset busy",   if1.busy,   1'b0);

        if0.datin = 1'b1;
        send1("p01_good",   8'h01, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h01);
        send1("p01_bad",    8'h01, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h01);
        send1("p01_stop0",  8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h01);
        send1("p03_good",   8'h03, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h03);
        send1("pC7_bad",    8'hC7, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h03);

        // The no-parity receiver stayed idle throughout.
        chk("np idle datout", if0.datout, 8'h81);
        chk("np idle busy",   if0.busy,   1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
